// File: rtl/request_demux_pkg.sv
// ============================================================================
// Module : request_demux_pkg
// Brief  : Shared defaults and helpers for the buffered request demux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package request_demux_pkg;

    localparam int DEF_NUM_METH  = 2;
    localparam int DEF_MSG_WIDTH = 192;
    localparam int DEF_TAG_WIDTH = 32;
    localparam int DEF_ARG_WIDTH = 64;
    localparam int DEF_DEPTH     = 4;

    localparam logic [15:0] BAD_CNT_MAX = 16'hFFFF;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/request_demux_fifo.sv
// ============================================================================
// Module : request_demux_fifo
// Brief  : Per-channel FIFO with wrap-around pointers and occupancy counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module request_demux_fifo
    import request_demux_pkg::*;
#(
    parameter int WIDTH = DEF_ARG_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)      r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

    // Storage is not reset: contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/request_demux_buffered.sv
// ============================================================================
// Module : request_demux_buffered
// Brief  : Tag-based demux of pipe messages into NUM_METH buffered channels.
//          Optional statistics outputs enabled by REQUEST_DEMUX_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module request_demux_buffered
    import request_demux_pkg::*;
#(
    parameter int NUM_METH  = DEF_NUM_METH,
    parameter int MSG_WIDTH = DEF_MSG_WIDTH,
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int ARG_WIDTH = DEF_ARG_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          pipe_enq__ENA,
    input  logic [MSG_WIDTH-1:0]          pipe_enq_v,
    output logic                          pipe_enq__RDY,
    output logic [NUM_METH-1:0]           request_out__ENA,
    output logic [NUM_METH*ARG_WIDTH-1:0] request_out_data,
    input  logic [NUM_METH-1:0]           request_out__RDY,
    output logic [15:0]                   bad_tag_count
`ifdef REQUEST_DEMUX_STATS_EN
    ,
    output logic [NUM_METH*32-1:0]                    dispatch_count,
    output logic [NUM_METH*(clog2(DEPTH)+1)-1:0]      max_occupancy
`endif
);

    localparam int CW = clog2(DEPTH) + 1;

    logic [TAG_WIDTH-1:0] w_tag;
    logic [ARG_WIDTH-1:0] w_arg;
    logic                 w_tag_ok;
    logic                 w_accept;
    logic [NUM_METH-1:0]  w_full;
    logic [15:0]          r_bad_cnt;

    assign w_tag    = pipe_enq_v[TAG_WIDTH-1:0];
    assign w_arg    = pipe_enq_v[TAG_WIDTH +: ARG_WIDTH];
    assign w_tag_ok = (w_tag != '0) && (w_tag <= TAG_WIDTH'(NUM_METH));
    assign w_accept = pipe_enq__ENA & pipe_enq__RDY;

    // Ready depends only on FIFO fullness, never on the message contents.
    assign pipe_enq__RDY = ~|w_full;
    assign bad_tag_count = r_bad_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bad_cnt <= '0;
        end else if (w_accept && !w_tag_ok && (r_bad_cnt != BAD_CNT_MAX)) begin
            r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    generate
        if (MSG_WIDTH > TAG_WIDTH + ARG_WIDTH) begin : g_spare_bits
            logic w_unused_msg;
            assign w_unused_msg = ^pipe_enq_v[MSG_WIDTH-1:TAG_WIDTH+ARG_WIDTH];
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_METH; i++) begin : g_chan
            logic                 w_push;
            logic                 w_empty;
            logic [ARG_WIDTH-1:0] w_head;
            logic [CW-1:0]        w_count;

            assign w_push = w_accept && w_tag_ok && (w_tag == TAG_WIDTH'(i + 1));

            request_demux_fifo #(
                .WIDTH (ARG_WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (CLK),
                .rst       (RST),
                .push      (w_push),
                .push_data (w_arg),
                .pop       (request_out__ENA[i]),
                .head      (w_head),
                .empty     (w_empty),
                .full      (w_full[i]),
                .count     (w_count)
            );

            assign request_out__ENA[i] = !w_empty && request_out__RDY[i];
            assign request_out_data[i*ARG_WIDTH +: ARG_WIDTH] = w_head;

`ifdef REQUEST_DEMUX_STATS_EN
            logic [31:0]   r_disp_cnt;
            logic [CW-1:0] r_max_occ;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_disp_cnt <= '0;
                    r_max_occ  <= '0;
                end else begin
                    if (request_out__ENA[i]) r_disp_cnt <= r_disp_cnt + 32'd1;
                    if (w_count > r_max_occ) r_max_occ  <= w_count;
                end
            end

            assign dispatch_count[i*32 +: 32] = r_disp_cnt;
            assign max_occupancy[i*CW +: CW]  = r_max_occ;
`else
            logic w_unused_count;
            assign w_unused_count = ^w_count;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_request_demux_buffered.sv
// ============================================================================
// Module : tb_request_demux_buffered
// Brief  : Directed + random checks of request_demux_buffered against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_request_demux_buffered;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         enq_ena = 1'b0;
    logic [191:0] enq_v = '0;
    logic         enq_rdy;
    logic [1:0]   out_ena;
    logic [127:0] out_data;
    logic [1:0]   out_rdy = 2'b00;
    logic [15:0]  bad_cnt;
`ifdef REQUEST_DEMUX_STATS_EN
    logic [63:0]  disp_cnt;
    logic [5:0]   max_occ;
`endif

    int total = 0;
    int n_bad = 0;

    // Reference model: one queue per channel plus a saturating drop counter.
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [15:0] model_bad = '0;

    request_demux_buffered dut (
        .CLK              (CLK),
        .RST              (RST),
        .pipe_enq__ENA    (enq_ena),
        .pipe_enq_v       (enq_v),
        .pipe_enq__RDY    (enq_rdy),
        .request_out__ENA (out_ena),
        .request_out_data (out_data),
        .request_out__RDY (out_rdy),
        .bad_tag_count    (bad_cnt)
`ifdef REQUEST_DEMUX_STATS_EN
        ,
        .dispatch_count   (disp_cnt),
        .max_occupancy    (max_occ)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] mk(input logic [31:0] tag, input logic [63:0] arg);
        return {$urandom(), $urandom(), $urandom(), arg, tag};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Drive one cycle of inputs, check outputs against the model, then advance.
    task automatic step(input logic en, input logic [191:0] v, input logic [1:0] ordy);
        logic       rdy_e;
        logic [1:0] ena_e;
        logic [31:0] tg;
        enq_ena = en;
        enq_v   = v;
        out_rdy = ordy;
        #1;
        rdy_e = (q0.size() < 4) && (q1.size() < 4);
        ena_e = {(q1.size() > 0) && ordy[1], (q0.size() > 0) && ordy[0]};
        chk("rdy", {63'd0, enq_rdy}, {63'd0, rdy_e});
        chk("ena", {62'd0, out_ena}, {62'd0, ena_e});
        chk("bad_cnt", {48'd0, bad_cnt}, {48'd0, model_bad});
        if (q0.size() > 0) chk("data0", out_data[63:0], q0[0]);
        if (q1.size() > 0) chk("data1", out_data[127:64], q1[0]);
        @(posedge CLK);
        if (ena_e[0]) void'(q0.pop_front());
        if (ena_e[1]) void'(q1.pop_front());
        if (en && rdy_e) begin
            tg = v[31:0];
            if (tg == 32'd1)      q0.push_back(v[95:32]);
            else if (tg == 32'd2) q1.push_back(v[95:32]);
            else if (model_bad != 16'hFFFF) model_bad = model_bad + 16'd1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] tg;

        // Reset then idle
        #12;
        RST = 1'b0;
        @(posedge CLK); #1;
        out_rdy = 2'b11;
        #1;
        chk("reset_rdy", {63'd0, enq_rdy}, 64'd1);
        chk("reset_ena", {62'd0, out_ena}, 64'd0);
        chk("reset_bad", {48'd0, bad_cnt}, 64'd0);
        @(posedge CLK); #1;

        // Single message, visible exactly one cycle later on channel 1
        step(1'b1, mk(32'd2, {32'h1234, 32'h7}), 2'b11);
        enq_ena = 1'b0;
        #1;
        chk("single_ena", {62'd0, out_ena}, 64'h2);
        chk("single_data", out_data[127:64], 64'h0000_1234_0000_0007);
        step(1'b0, '0, 2'b11);
        step(1'b0, '0, 2'b11);

        // Backpressure on channel 0
        for (int k = 0; k < 4; k++) step(1'b1, mk(32'd1, rnd64()), 2'b10);
        enq_ena = 1'b0;
        #1;
        chk("bp_rdy_low", {63'd0, enq_rdy}, 64'd0);
        step(1'b1, mk(32'd2, rnd64()), 2'b10);
        chk("bp_refused_q1", 64'(q1.size()), 64'd0);
        for (int k = 0; k < 5; k++) step(1'b0, '0, 2'b11);
        enq_ena = 1'b0;
        #1;
        chk("bp_rdy_back", {63'd0, enq_rdy}, 64'd1);

        // Bad tags
        step(1'b1, mk(32'd0, rnd64()), 2'b11);
        step(1'b1, mk(32'd3, rnd64()), 2'b11);
        step(1'b1, mk(32'hFFFF_FFFF, rnd64()), 2'b11);
        step(1'b0, '0, 2'b11);
        chk("bad_three", {48'd0, bad_cnt}, 64'd3);

        // Saturation: 65535 more drops takes the total to 65538
        enq_ena = 1'b1;
        enq_v   = mk(32'd0, rnd64());
        repeat (65535) @(posedge CLK);
        #1;
        enq_ena = 1'b0;
        model_bad = 16'hFFFF;
        #1;
        chk("bad_saturate", {48'd0, bad_cnt}, 64'hFFFF);
        @(posedge CLK); #1;
        step(1'b1, mk(32'd5, rnd64()), 2'b11);
        step(1'b0, '0, 2'b11);

        // Concurrent push/pop on channel 0 holding 2 entries, across pointer wrap
        step(1'b1, mk(32'd1, rnd64()), 2'b00);
        step(1'b1, mk(32'd1, rnd64()), 2'b00);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, mk(32'd1, rnd64()), 2'b01);
            chk("concurrent_occ", 64'(q0.size()), 64'd2);
        end
        for (int k = 0; k < 3; k++) step(1'b0, '0, 2'b11);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 4))
                0:       tg = 32'd0;
                1, 2:    tg = 32'd1;
                3:       tg = 32'd2;
                default: tg = $urandom();
            endcase
            step(1'($urandom_range(0, 1)), mk(tg, rnd64()), 2'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 6; k++) step(1'b0, '0, 2'b11);

        // Mid-operation asynchronous reset with 3 entries queued
        for (int k = 0; k < 3; k++) step(1'b1, mk(32'd1, rnd64()), 2'b00);
        enq_ena = 1'b0;
        out_rdy = 2'b11;
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_ena", {62'd0, out_ena}, 64'd0);
        chk("async_rst_rdy", {63'd0, enq_rdy}, 64'd1);
        chk("async_rst_bad", {48'd0, bad_cnt}, 64'd0);
`ifdef REQUEST_DEMUX_STATS_EN
        chk("async_rst_disp", disp_cnt, 64'd0);
        chk("async_rst_occ", {58'd0, max_occ}, 64'd0);
`endif
        q0.delete();
        q1.delete();
        model_bad = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        step(1'b0, '0, 2'b11);
        step(1'b1, mk(32'd2, rnd64()), 2'b11);
        step(1'b0, '0, 2'b11);

        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
